// File: rtl/dbus_fabric_if.sv
// Data-bus bundle between the CPU data port, the fabric and its NSLV slave ports.
// `slave` is the fabric's view; `master` is the environment's view (CPU plus slave devices).
interface dbus_fabric_if #(
  parameter int unsigned NSLV   = 4,
  parameter int unsigned DATA_W = 32
);
  logic                     m_req;
  logic                     m_we;
  logic [DATA_W/8-1:0]      m_wstrb;
  logic [31:0]              m_addr;
  logic [DATA_W-1:0]        m_wdata;
  logic [DATA_W-1:0]        m_rdata;
  logic                     m_ready;
  logic                     m_err;
  logic [NSLV-1:0]          s_sel;
  logic                     s_we;
  logic [DATA_W/8-1:0]      s_wstrb;
  logic [31:0]              s_addr;
  logic [DATA_W-1:0]        s_wdata;
  logic [NSLV*DATA_W-1:0]   s_rdata;
  logic [NSLV-1:0]          s_ready;

  modport slave (
    input  m_req, m_we, m_wstrb, m_addr, m_wdata,
    output m_rdata, m_ready, m_err,
    output s_sel, s_we, s_wstrb, s_addr, s_wdata,
    input  s_rdata, s_ready
  );

  modport master (
    output m_req, m_we, m_wstrb, m_addr, m_wdata,
    input  m_rdata, m_ready, m_err,
    input  s_sel, s_we, s_wstrb, s_addr, s_wdata,
    output s_rdata, s_ready
  );
endinterface

// File: rtl/dbus_fabric.sv
// Data-bus interconnect: address decode to NSLV slaves, per-slave wait states,
// decode-error/timeout detection, registered read data and error-status capture.
module dbus_fabric #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter logic [32*NSLV-1:0] SLV_BASE =
    {32'hFFFF0000, 32'hFFFFFD00, 32'hFFFFFC00, 32'h00000000},
  parameter logic [32*NSLV-1:0] SLV_MASK =
    {32'hFFFF0000, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFFFF0000}
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dbus_fabric_if.slave bus,
  output logic [31:0]  err_addr_o,
  output logic [7:0]   err_cnt_o
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StAccess, StResp, StDerr, StTerr} state_e;

  state_e              state_q, state_d;
  logic [NSLV-1:0]     sel_q, sel_d, dec_sel;
  logic                we_q, we_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   slv_rdata;
  logic [CntW-1:0]     wait_q, wait_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                slv_ready;
  logic                timeout_hit;

  // Descending scan so the lowest matching slot overrides any catch-all above it.
  always_comb begin
    dec_sel = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q[i]) slv_rdata = slv_rdata | bus.s_rdata[DATA_W*i +: DATA_W];
    end
    slv_ready   = |(sel_q & bus.s_ready);
    timeout_hit = (TIMEOUT != 0) && (wait_q == CntW'(TIMEOUT - 1));
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    wstrb_d    = wstrb_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m_req) begin
          we_d    = bus.m_we;
          wstrb_d = bus.m_we ? bus.m_wstrb : '0;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          wait_d  = '0;
          if (|dec_sel) begin
            sel_d   = dec_sel;
            state_d = StAccess;
          end else begin
            state_d = StDerr;
          end
        end
      end
      StAccess: begin
        // A ready in the final wait cycle takes priority over the timeout.
        if (slv_ready) begin
          rdata_d = we_q ? '0 : slv_rdata;
          sel_d   = '0;
          state_d = StResp;
        end else if (timeout_hit) begin
          sel_d   = '0;
          state_d = StTerr;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StResp: state_d = StIdle;
      StDerr, StTerr: begin
        err_addr_d = addr_q;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_q     <= wait_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    bus.m_ready = (state_q == StResp);
    bus.m_err   = (state_q == StDerr) || (state_q == StTerr);
    if (bus.m_err)        bus.m_rdata = '1;
    else if (bus.m_ready) bus.m_rdata = rdata_q;
    else                  bus.m_rdata = '0;
    bus.s_sel   = sel_q;
    bus.s_we    = we_q;
    bus.s_wstrb = wstrb_q;
    bus.s_addr  = addr_q;
    bus.s_wdata = wdata_q;
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_dbus_fabric.sv
// Directed bench for dbus_fabric: decode, wait states, write path, decode error,
// timeout vs late ready, reset abort and error-count saturation.
module tb_dbus_fabric;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  dbus_fabric_if #(.NSLV(4), .DATA_W(32)) bus ();

  dbus_fabric #(.NSLV(4), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .err_addr_o (err_addr),
    .err_cnt_o  (err_cnt)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] slv_data [4];
  int          slv_wait [4];
  logic [3:0]  stall = '0;
  logic [3:0]  junk = '0;
  int          scnt = 0;

  // Slave model: selected slave answers after slv_wait[i] wait cycles; junk drives unselected readies.
  always @(posedge clk) scnt <= (bus.s_sel != '0) ? scnt + 1 : 0;

  for (genvar g = 0; g < 4; g++) begin : g_slv
    assign bus.s_ready[g] = (bus.s_sel[g] && !stall[g] && (scnt == slv_wait[g])) ||
                            (!bus.s_sel[g] && junk[g]);
    assign bus.s_rdata[32*g +: 32] = slv_data[g];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // lat = index of the clock edge (counted from the accept edge) at which the master sees completion.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output int lat, output logic rdy,
                        output logic err, output logic [31:0] rdata, output logic [3:0] sel_s,
                        output logic [3:0] wstrb_s, output logic [31:0] wdata_s,
                        output logic we_s);
    @(negedge clk);
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wstrb = wstrb;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    sel_s   = bus.s_sel;
    wstrb_s = bus.s_wstrb;
    wdata_s = bus.s_wdata;
    we_s    = bus.s_we;
    while (!bus.m_ready && !bus.m_err && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    rdy   = bus.m_ready;
    err   = bus.m_err;
    rdata = bus.m_rdata;
    bus.m_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int          lat;
  logic        rdy, err, we_s, seen;
  logic [31:0] rdata, wdata_s;
  logic [3:0]  sel_s, wstrb_s;

  initial begin
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    slv_data[0] = 32'h12345678; slv_data[1] = 32'hDEADBEEF;
    slv_data[2] = 32'h0BADF00D; slv_data[3] = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) slv_wait[i] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst m_rdata", bus.m_rdata, 32'h0);
    chk("rst flags", {bus.m_ready, bus.m_err, bus.s_sel, bus.s_we, bus.s_wstrb}, 11'h0);
    chk("rst s_addr/wdata", {bus.s_addr, bus.s_wdata}, 64'h0);
    chk("rst err", {err_addr, err_cnt}, 40'h0);
    rst_n = 1'b1;

    // Zero-wait read from slot 0; strobes must be dropped on reads.
    access(1'b0, 32'h00000010, 32'h0, 4'hF, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t1 sel", sel_s, 4'b0001);
    chk("t1 rd wstrb", wstrb_s, 4'h0);
    chk("t1 latency", lat, 2);
    chk("t1 ready/err", {rdy, err}, 2'b10);
    chk("t1 rdata", rdata, 32'h12345678);

    access(1'b1, 32'hFFFFFC60, 32'h000000A5, 4'b0001, lat, rdy, err, rdata, sel_s, wstrb_s,
           wdata_s, we_s);
    chk("t2 sel", sel_s, 4'b0010);
    chk("t2 s_we/wstrb", {we_s, wstrb_s}, 5'b1_0001);
    chk("t2 s_wdata", wdata_s, 32'h000000A5);
    chk("t2 ready/err", {rdy, err}, 2'b10);
    chk("t2 rdata", rdata, 32'h0);

    slv_wait[2] = 2;
    access(1'b0, 32'hFFFFFD04, 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t2b sel", sel_s, 4'b0100);
    chk("t2b latency", lat, 4);
    chk("t2b rdata", rdata, 32'h0BADF00D);

    access(1'b0, 32'h80000000, 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t3 sel", sel_s, 4'b0000);
    chk("t3 latency", lat, 1);
    chk("t3 ready/err", {rdy, err}, 2'b01);
    chk("t3 rdata", rdata, 32'hFFFFFFFF);
    chk("t3 err_addr", err_addr, 32'h80000000);
    chk("t3 err_cnt", err_cnt, 8'd1);

    // Slot 3 never answers while the other slots wave their readies.
    stall = 4'b1000; junk = 4'b0111;
    access(1'b0, 32'hFFFF1000, 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t4 sel", sel_s, 4'b1000);
    chk("t4 latency", lat, 256);
    chk("t4 ready/err", {rdy, err}, 2'b01);
    chk("t4 rdata", rdata, 32'hFFFFFFFF);
    chk("t4 err_addr", err_addr, 32'hFFFF1000);
    chk("t4 err_cnt", err_cnt, 8'd2);

    stall = '0; junk = '0; slv_wait[3] = 254;
    access(1'b0, 32'hFFFF1000, 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t4b latency", lat, 256);
    chk("t4b ready/err", {rdy, err}, 2'b10);
    chk("t4b rdata", rdata, 32'hCAFEF00D);
    chk("t4b err_cnt", err_cnt, 8'd2);

    // Reset mid-access with a 3-wait slave.
    slv_wait[0] = 3;
    @(negedge clk);
    bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_addr = 32'h00000020;
    @(posedge clk);
    @(negedge clk);
    chk("t5 sel", bus.s_sel, 4'b0001);
    rst_n = 1'b0;
    bus.m_req = 1'b0;
    @(negedge clk);
    chk("t5 rst sel", bus.s_sel, 4'b0000);
    chk("t5 err_cnt", err_cnt, 8'd0);
    seen = bus.m_ready | bus.m_err;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.m_ready | bus.m_err;
    end
    chk("t5 no response", seen, 1'b0);
    access(1'b0, 32'h00000020, 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s, wdata_s, we_s);
    chk("t5b latency", lat, 5);
    chk("t5b ready/err", {rdy, err}, 2'b10);
    chk("t5b rdata", rdata, 32'h12345678);

    for (int i = 0; i < 300; i++) begin
      access(1'b0, 32'h80000000 + 32'(4 * i), 32'h0, 4'h0, lat, rdy, err, rdata, sel_s, wstrb_s,
             wdata_s, we_s);
      if (i == 253) chk("t6 err_cnt 254", err_cnt, 8'd254);
    end
    chk("t6 err_cnt sat", err_cnt, 8'd255);
    chk("t6 err_addr", err_addr, 32'h800004AC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
